// File: rtl/ddr4_ca_lane_dly_ctrl.sv
// DDR4 command/address output-lane controller: registers TX/OE slot data per lane and
// sequences each lane's IOD delay line (LOAD/MOVE/DIRECTION) while tracking its tap value.
module ddr4_ca_lane_dly_ctrl #(
  parameter int   LANES    = 4,
  parameter int   GEAR     = 4,
  parameter int   TAP_W    = 8,
  parameter int   TAP_MAX  = 255,
  parameter int   LOAD_TAP = 1,
  parameter int   MOVE_GAP = 2,
  parameter logic IDLE_VAL = 1'b1,
  localparam int  LW       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     i_fab_clk,
  input  logic                     i_arst_n,
  input  logic                     i_cmd_valid,
  input  logic [LANES*GEAR-1:0]    i_cmd_data,
  input  logic                     i_oe_en,
  output logic [LANES*GEAR-1:0]    o_tx_data,
  output logic [LANES*GEAR-1:0]    o_oe_data,
  input  logic                     i_adj_req,
  input  logic [LW-1:0]            i_adj_lane,
  input  logic                     i_adj_load,
  input  logic                     i_adj_dir,
  input  logic [TAP_W-1:0]         i_adj_steps,
  output logic                     o_adj_busy,
  output logic                     o_adj_ack,
  output logic                     o_adj_err,
  output logic [LANES*TAP_W-1:0]   o_tap_val,
  output logic [LANES-1:0]         o_delay_line_load,
  output logic [LANES-1:0]         o_delay_line_move,
  output logic [LANES-1:0]         o_delay_line_direction,
  input  logic [LANES-1:0]         i_delay_line_out_of_range
);

  localparam int GW = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MOVE, S_GAP, S_DONE} state_t;

  state_t             r_state;
  logic [LW-1:0]      r_lane;
  logic               r_dir;
  logic [TAP_W-1:0]   r_rem;
  logic [GW-1:0]      r_gap;
  logic               r_busy;
  logic               r_ack;
  logic               r_err;
  logic [LANES-1:0]   r_load;
  logic [LANES-1:0]   r_move;
  logic [LANES-1:0]   r_direction;
  logic [TAP_W-1:0]   r_tap [LANES];
  logic [LANES*GEAR-1:0] r_tx;
  logic [LANES*GEAR-1:0] r_oe;

  logic               w_req_lane_ok;
  logic [TAP_W-1:0]   w_req_tap;
  logic               w_req_block;
  logic [TAP_W-1:0]   w_cur_tap;
  logic               w_cur_block;

  // The next MOVE is vetted one cycle ahead (in IDLE or at the end of GAP) so an
  // abort goes straight to DONE without spending a cycle in MOVE.
  always_comb begin
    w_req_lane_ok = (int'(i_adj_lane) < LANES);
    w_req_tap     = w_req_lane_ok ? r_tap[i_adj_lane] : '0;
    w_req_block   = i_delay_line_out_of_range[i_adj_lane] |
                    (i_adj_dir ? (w_req_tap == TAP_W'(TAP_MAX)) : (w_req_tap == '0));
    w_cur_tap     = r_tap[r_lane];
    w_cur_block   = i_delay_line_out_of_range[r_lane] |
                    (r_dir ? (w_cur_tap == TAP_W'(TAP_MAX)) : (w_cur_tap == '0));
  end

  always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_tx <= {(LANES*GEAR){IDLE_VAL}};
      r_oe <= '0;
    end else begin
      r_tx <= i_cmd_valid ? i_cmd_data : {(LANES*GEAR){IDLE_VAL}};
      r_oe <= {(LANES*GEAR){i_oe_en}};
    end
  end

  always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state     <= S_IDLE;
      r_lane      <= '0;
      r_dir       <= 1'b0;
      r_rem       <= '0;
      r_gap       <= '0;
      r_busy      <= 1'b0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_load      <= '0;
      r_move      <= '0;
      r_direction <= '0;
      for (int l = 0; l < LANES; l++) begin
        r_tap[l] <= TAP_W'(LOAD_TAP);
      end
    end else begin
      r_load <= '0;
      r_move <= '0;
      r_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_adj_req) begin
            r_lane <= i_adj_lane;
            r_dir  <= i_adj_dir;
            r_rem  <= i_adj_steps;
            r_err  <= 1'b0;
            r_busy <= 1'b1;
            if (!w_req_lane_ok) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else if (i_adj_load) begin
              r_state <= S_LOAD;
            end else begin
              r_direction[i_adj_lane] <= i_adj_dir;
              if (i_adj_steps == '0) begin
                r_state <= S_DONE;
              end else if (w_req_block) begin
                r_err   <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_MOVE;
              end
            end
          end
        end
        S_LOAD: begin
          r_load[r_lane] <= 1'b1;
          r_tap[r_lane]  <= TAP_W'(LOAD_TAP);
          r_state        <= S_DONE;
        end
        S_MOVE: begin
          r_move[r_lane] <= 1'b1;
          r_tap[r_lane]  <= r_dir ? (w_cur_tap + TAP_W'(1)) : (w_cur_tap - TAP_W'(1));
          r_rem          <= r_rem - TAP_W'(1);
          r_gap          <= GW'(MOVE_GAP - 1);
          r_state        <= S_GAP;
        end
        S_GAP: begin
          if (r_gap == '0) begin
            if (r_rem == '0) begin
              r_state <= S_DONE;
            end else if (w_cur_block) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_MOVE;
            end
          end else begin
            r_gap <= r_gap - GW'(1);
          end
        end
        S_DONE: begin
          r_ack   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_tap_out
      assign o_tap_val[gi*TAP_W +: TAP_W] = r_tap[gi];
    end
  endgenerate

  assign o_tx_data              = r_tx;
  assign o_oe_data              = r_oe;
  assign o_adj_busy             = r_busy;
  assign o_adj_ack              = r_ack;
  assign o_adj_err              = r_err;
  assign o_delay_line_load      = r_load;
  assign o_delay_line_move      = r_move;
  assign o_delay_line_direction = r_direction;

endmodule

// File: tb/tb_ddr4_ca_lane_dly_ctrl.sv
// Scoreboard bench for ddr4_ca_lane_dly_ctrl: stimulus queues expected datapath words,
// delay-line pulses and ACK records; a negedge monitor pops and compares them.
module tb_ddr4_ca_lane_dly_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_data = '0;
  logic        oe_en = 1'b1;
  logic [15:0] tx_data, oe_data;
  logic        adj_req = 1'b0;
  logic [1:0]  adj_lane = '0;
  logic        adj_load = 1'b0;
  logic        adj_dir = 1'b0;
  logic [7:0]  adj_steps = '0;
  logic        adj_busy, adj_ack, adj_err;
  logic [31:0] tap_val;
  logic [3:0]  dl_load, dl_move, dl_dir;
  logic [3:0]  dl_oor = '0;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {int cyc; logic [15:0] tx; logic [15:0] oe;} dp_t;
  typedef struct {int cyc; logic is_load; int lane;} pulse_t;
  typedef struct {int cyc; logic err; int lane; logic [7:0] tap; logic chk_dir; logic dir;} ack_t;

  dp_t    dp_q[$];
  pulse_t pulse_q[$];
  ack_t   ack_q[$];

  ddr4_ca_lane_dly_ctrl dut (
    .i_fab_clk                 (clk),
    .i_arst_n                  (rst_n),
    .i_cmd_valid               (cmd_valid),
    .i_cmd_data                (cmd_data),
    .i_oe_en                   (oe_en),
    .o_tx_data                 (tx_data),
    .o_oe_data                 (oe_data),
    .i_adj_req                 (adj_req),
    .i_adj_lane                (adj_lane),
    .i_adj_load                (adj_load),
    .i_adj_dir                 (adj_dir),
    .i_adj_steps               (adj_steps),
    .o_adj_busy                (adj_busy),
    .o_adj_ack                 (adj_ack),
    .o_adj_err                 (adj_err),
    .o_tap_val                 (tap_val),
    .o_delay_line_load         (dl_load),
    .o_delay_line_move         (dl_move),
    .o_delay_line_direction    (dl_dir),
    .i_delay_line_out_of_range (dl_oor)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "global timeout");
  end

  // Monitor: compares whatever the DUT presents against the head of each queue.
  always @(negedge clk) begin : monitor
    dp_t d;
    pulse_t p;
    ack_t a;
    logic [3:0] em, el;
    if (rst_n) begin
      if (dp_q.size() > 0 && dp_q[0].cyc <= cyc) begin
        d = dp_q.pop_front();
        checks++;
        if (d.cyc != cyc || tx_data !== d.tx || oe_data !== d.oe) begin
          errors++;
          $display("FAIL datapath cyc=%0d tx=%h oe=%h expected cyc=%0d tx=%h oe=%h",
                   cyc, tx_data, oe_data, d.cyc, d.tx, d.oe);
        end
      end
      if ((dl_move | dl_load) != 4'b0) begin
        checks++;
        if (pulse_q.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected cyc=%0d move=%b load=%b expected none", cyc, dl_move, dl_load);
        end else begin
          p  = pulse_q.pop_front();
          em = p.is_load ? 4'b0 : (4'b1 << p.lane);
          el = p.is_load ? (4'b1 << p.lane) : 4'b0;
          if (p.cyc != cyc || dl_move !== em || dl_load !== el) begin
            errors++;
            $display("FAIL pulse cyc=%0d move=%b load=%b expected cyc=%0d move=%b load=%b",
                     cyc, dl_move, dl_load, p.cyc, em, el);
          end
        end
      end else if (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
        p = pulse_q.pop_front();
        checks++;
        errors++;
        $display("FAIL pulse_missing cyc=%0d got none expected lane=%0d at cyc=%0d", cyc, p.lane, p.cyc);
      end
      if (adj_ack === 1'b1) begin
        checks++;
        if (ack_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected cyc=%0d expected no ack", cyc);
        end else begin
          a = ack_q.pop_front();
          if (a.cyc != cyc || adj_err !== a.err || tap_val[a.lane*8 +: 8] !== a.tap ||
              adj_busy !== 1'b0 || (a.chk_dir && dl_dir[a.lane] !== a.dir)) begin
            errors++;
            $display("FAIL ack cyc=%0d err=%b tap=%0d busy=%b dir=%b expected cyc=%0d err=%b tap=%0d busy=0 dir=%b",
                     cyc, adj_err, tap_val[a.lane*8 +: 8], adj_busy, dl_dir[a.lane],
                     a.cyc, a.err, a.tap, a.dir);
          end
        end
      end else if (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
        a = ack_q.pop_front();
        checks++;
        errors++;
        $display("FAIL ack_missing cyc=%0d got none expected at cyc=%0d", cyc, a.cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic issue(input int lane, input bit ld, input bit dir, input int steps, output int acc);
    adj_lane  = 2'(lane);
    adj_load  = ld;
    adj_dir   = dir;
    adj_steps = 8'(steps);
    adj_req   = 1'b1;
    acc       = cyc + 1;
    @(negedge clk);
    adj_req   = 1'b0;
  endtask

  task automatic push_moves(input int acc, input int lane, input int n);
    for (int k = 0; k < n; k++) pulse_q.push_back('{acc + 1 + k*3, 1'b0, lane});
  endtask

  task automatic push_ack(input int c, input bit err, input int lane, input int tap,
                          input bit chk_dir, input bit dir);
    ack_q.push_back('{c, err, lane, 8'(tap), chk_dir, dir});
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((ack_q.size() > 0 || pulse_q.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (ack_q.size() > 0 || pulse_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout cyc=%0d pending_acks=%0d pending_pulses=%0d expected 0",
               cyc, ack_q.size(), pulse_q.size());
      ack_q.delete();
      pulse_q.delete();
    end
  endtask

  initial begin
    int acc;
    // 1: reset values, then first registered datapath word
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx_data), 32'hFFFF);
    chk("reset_oe", 32'(oe_data), 32'h0);
    chk("reset_tap", tap_val, 32'h01010101);
    chk("reset_ctl", {29'b0, adj_busy, adj_ack, adj_err}, 32'h0);
    chk("reset_dl", {20'b0, dl_load, dl_move, dl_dir}, 32'h0);
    rst_n = 1'b1;
    dp_q.push_back('{cyc + 1, 16'hFFFF, 16'hFFFF});
    @(negedge clk);
    // 2: datapath
    cmd_valid = 1'b1; cmd_data = 16'hA5C3;
    dp_q.push_back('{cyc + 1, 16'hA5C3, 16'hFFFF});
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = 16'h1234;
    dp_q.push_back('{cyc + 1, 16'hFFFF, 16'hFFFF});
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 16'h0F0F; oe_en = 1'b0;
    dp_q.push_back('{cyc + 1, 16'h0F0F, 16'h0000});
    @(negedge clk);
    cmd_valid = 1'b0; oe_en = 1'b1;
    dp_q.push_back('{cyc + 1, 16'hFFFF, 16'hFFFF});
    repeat (2) @(negedge clk);
    chk("dp_drained", 32'(dp_q.size()), 32'h0);
    // 3: lane 2 up 3 -> pulses 1,4,7, ACK 10, tap 4
    issue(2, 0, 1, 3, acc);
    push_moves(acc, 2, 3);
    push_ack(acc + 10, 0, 2, 4, 1, 1);
    wait_done(40);
    // 4: lane 1 down 5 from tap 1 -> one pulse, ACK 4 with ERR, tap 0
    issue(1, 0, 0, 5, acc);
    push_moves(acc, 1, 1);
    push_ack(acc + 4, 1, 1, 0, 1, 0);
    wait_done(40);
    chk("err_held", 32'(adj_err), 32'h1);
    // 5: lane 3 up 4, OUT_OF_RANGE after 2nd pulse -> tap 3, ACK 7 with ERR
    issue(3, 0, 1, 4, acc);
    push_moves(acc, 3, 2);
    push_ack(acc + 7, 1, 3, 3, 1, 1);
    while (cyc < acc + 4) @(negedge clk);
    dl_oor = 4'b1000;
    wait_done(40);
    dl_oor = 4'b0000;
    // then LOAD lane 3 -> LOAD pulse 1, ACK 2, tap 1
    issue(3, 1, 0, 9, acc);
    pulse_q.push_back('{acc + 1, 1'b1, 3});
    push_ack(acc + 2, 0, 3, 1, 1, 1);
    wait_done(40);
    // zero steps: no pulse, ACK 1, DIRECTION still updated
    issue(0, 0, 1, 0, acc);
    push_ack(acc + 1, 0, 0, 1, 1, 1);
    wait_done(40);
    // tap ceiling: 254 pulses from 1 reach 255, next step aborts
    issue(0, 0, 1, 255, acc);
    push_moves(acc, 0, 254);
    push_ack(acc + 1 + 254*3, 1, 0, 255, 1, 1);
    wait_done(900);
    issue(0, 1, 0, 0, acc);
    pulse_q.push_back('{acc + 1, 1'b1, 0});
    push_ack(acc + 2, 0, 0, 1, 1, 1);
    wait_done(40);
    // 6: request while busy is ignored
    issue(0, 0, 1, 2, acc);
    push_moves(acc, 0, 2);
    push_ack(acc + 7, 0, 0, 3, 1, 1);
    @(negedge clk);
    adj_lane = 2'd1; adj_load = 1'b1; adj_req = 1'b1;
    @(negedge clk);
    adj_req = 1'b0;
    wait_done(40);
    chk("busy_ignored_tap1", 32'(tap_val[15:8]), 32'h0);
    // reset in the middle of a move
    cmd_valid = 1'b1; cmd_data = 16'h0000;
    issue(0, 0, 1, 3, acc);
    push_moves(acc, 0, 1);
    while (cyc < acc + 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_tap", tap_val, 32'h01010101);
    chk("midrst_tx_oe", {tx_data, oe_data}, 32'hFFFF0000);
    chk("midrst_ctl", {29'b0, adj_busy, adj_ack, adj_err}, 32'h0);
    chk("midrst_dl", {20'b0, dl_load, dl_move, dl_dir}, 32'h0);
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_tap", tap_val, 32'h01010101);
    chk("post_rst_busy", 32'(adj_busy), 32'h0);
    chk("queues_empty", 32'(ack_q.size() + pulse_q.size() + dp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
